// File: rtl/datapath_arbiter_if.sv
// Bus bundle between the two sequencing controllers, the FIR datapath and
// datapath_arbiter. The master modport is the controller/datapath side; the
// slave modport is the arbiter. Optional ARB_STATS_EN adds grant counters.
interface datapath_arbiter_if;
    logic       req0;
    logic [2:0] op0;
    logic [3:0] src1_0;
    logic [3:0] src2_0;
    logic [3:0] dest_0;
    logic       req1;
    logic [2:0] op1;
    logic [3:0] src1_1;
    logic [3:0] src2_1;
    logic [3:0] dest_1;
    logic       overflow;
    logic       gnt0;
    logic       gnt1;
    logic       ovf0;
    logic       ovf1;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       err;
`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
`endif

    modport master (
        output req0, op0, src1_0, src2_0, dest_0,
        output req1, op1, src1_1, src2_1, dest_1,
        output overflow,
        input  gnt0, gnt1, ovf0, ovf1, op, src1, src2, dest, err
`ifdef ARB_STATS_EN
        , input gnt_cnt0, gnt_cnt1
`endif
    );

    modport slave (
        input  req0, op0, src1_0, src2_0, dest_0,
        input  req1, op1, src1_1, src2_1, dest_1,
        input  overflow,
        output gnt0, gnt1, ovf0, ovf1, op, src1, src2, dest, err
`ifdef ARB_STATS_EN
        , output gnt_cnt0, gnt_cnt1
`endif
    );
endinterface

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: shares the FIR register-file datapath between the
// sample-processing controller (requester 0, high priority) and the
// coefficient-load controller (requester 1). Whole bursts are granted, a
// one-cycle NOP turnaround separates owners, requester 1 cannot be starved
// and a burst held too long is force-released with a sticky error.
// Optional feature macro: ARB_STATS_EN (adds saturating grant counters).
module datapath_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 64
) (
    input logic               clk,
    input logic               n_rst,
    datapath_arbiter_if.slave dp
);
    localparam int         SW     = $clog2(STARVE_LIMIT + 1);
    localparam int         BW     = $clog2(MAX_BURST);
    localparam logic [2:0] OP_NOP = 3'b000;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    mask_q, mask_d;
    logic          err_q, err_d;
    logic [2:0]    op_q;
    logic [3:0]    src1_q, src2_q, dest_q;
    logic          eff0, eff1, force1, starve_max, burst_max;

    // A requester force-released off a hung burst stays masked until it drops req.
    assign eff0       = dp.req0 & ~mask_q[0];
    assign eff1       = dp.req1 & ~mask_q[1];
    assign starve_max = (starve_q == SW'(STARVE_LIMIT));
    assign burst_max  = (burst_q == BW'(MAX_BURST - 1));
    assign force1     = eff1 & starve_max;

    // Next-state, starvation/burst counters, masking and error decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        starve_d = starve_q;
        burst_d  = burst_q;
        mask_d   = {dp.req1 & mask_q[1], dp.req0 & mask_q[0]};
        err_d    = err_q;
        case (state_q)
            IDLE, TURN: begin
                if (eff0 && !force1) begin
                    state_d  = GRANT0;
                    burst_d  = '0;
                    if (!dp.req1)       starve_d = '0;
                    else if (!starve_max) starve_d = starve_q + SW'(1);
                end else if (eff1) begin
                    state_d  = GRANT1;
                    burst_d  = '0;
                    starve_d = '0;
                end else begin
                    state_d = IDLE;
                    if (!dp.req1) starve_d = '0;
                end
            end
            GRANT0: begin
                if (!dp.req0) begin
                    state_d = TURN;
                end else if (burst_max) begin
                    state_d   = TURN;
                    err_d     = 1'b1;
                    mask_d[0] = 1'b1;
                end else begin
                    burst_d = burst_q + BW'(1);
                end
            end
            GRANT1: begin
                if (!dp.req1) begin
                    state_d = TURN;
                end else if (burst_max) begin
                    state_d   = TURN;
                    err_d     = 1'b1;
                    mask_d[1] = 1'b1;
                end else begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register; reset drops any grant immediately.
    // NOTE: asynchronous active-low reset, so the grant falls without waiting for clk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            burst_q  <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    // Datapath bus register: owner's fields one cycle later, NOP otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_q   <= OP_NOP;
            src1_q <= '0;
            src2_q <= '0;
            dest_q <= '0;
        end else begin
            case (state_q)
                GRANT0: begin
                    op_q   <= dp.op0;
                    src1_q <= dp.src1_0;
                    src2_q <= dp.src2_0;
                    dest_q <= dp.dest_0;
                end
                GRANT1: begin
                    op_q   <= dp.op1;
                    src1_q <= dp.src1_1;
                    src2_q <= dp.src2_1;
                    dest_q <= dp.dest_1;
                end
                default: op_q <= OP_NOP;
            endcase
        end
    end

    assign dp.gnt0 = (state_q == GRANT0);
    assign dp.gnt1 = (state_q == GRANT1);
    assign dp.ovf0 = dp.overflow & dp.gnt0;
    assign dp.ovf1 = dp.overflow & dp.gnt1;
    assign dp.op   = op_q;
    assign dp.src1 = src1_q;
    assign dp.src2 = src2_q;
    assign dp.dest = dest_q;
    assign dp.err  = err_q;

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

    // Saturating count of grants issued to each requester.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (state_d == GRANT0 && state_q != GRANT0 && gnt_cnt0_q != 16'hFFFF)
                gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (state_d == GRANT1 && state_q != GRANT1 && gnt_cnt1_q != 16'hFFFF)
                gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
        end
    end

    assign dp.gnt_cnt0 = gnt_cnt0_q;
    assign dp.gnt_cnt1 = gnt_cnt1_q;
`endif
endmodule

// File: tb/tb_datapath_arbiter.sv
// Testbench for datapath_arbiter: directed scenarios plus randomized bursts,
// checked against an owner-based reference model through a scoreboard queue.
module tb_datapath_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 64;

    typedef struct packed {
        logic       req;
        logic [2:0] op;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] d;
    } rq_t;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        ovf0;
        logic        ovf1;
        logic        err;
        logic [2:0]  op;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [15:0] c0;
        logic [15:0] c1;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    datapath_arbiter_if dp();

    datapath_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .MAX_BURST   (MAX_BURST)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .dp   (dp.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    exp_t q[$];

    // reference model: who owns the bus (-1 = nobody, i.e. idle or turnaround)
    int         m_owner;
    int         m_starve;
    int         m_held;
    bit         m_mask[2];
    bit         m_err;
    logic [2:0] m_op;
    logic [3:0] m_s1, m_s2, m_d;
    int         m_cnt[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic rq_t mk(input bit req, input logic [2:0] op);
        rq_t r;
        r.req = req;
        r.op  = op;
        r.s1  = 4'($urandom);
        r.s2  = 4'($urandom);
        r.d   = 4'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_starve = 0;
        m_held   = 0;
        m_mask   = '{0, 0};
        m_err    = 0;
        m_op     = 3'b000;
        m_s1     = 0;
        m_s2     = 0;
        m_d      = 0;
        m_cnt    = '{0, 0};
    endtask

    task automatic set_inputs(input rq_t a, input rq_t b, input bit ovf);
        dp.req0 = a.req; dp.op0 = a.op; dp.src1_0 = a.s1; dp.src2_0 = a.s2; dp.dest_0 = a.d;
        dp.req1 = b.req; dp.op1 = b.op; dp.src1_1 = b.s1; dp.src2_1 = b.s2; dp.dest_1 = b.d;
        dp.overflow = ovf;
    endtask

    // Apply one cycle of inputs (called at a negedge), predict the outputs after
    // the coming rising edge, queue them, and return at the following negedge.
    task automatic drive(input rq_t a, input rq_t b, input bit ovf);
        rq_t  r[2];
        bit   nm[2];
        bit   e0, e1;
        int   o;
        exp_t e;
        set_inputs(a, b, ovf);
        r[0] = a;
        r[1] = b;
        for (int i = 0; i < 2; i++) nm[i] = r[i].req ? m_mask[i] : 1'b0;
        if (m_owner >= 0) begin
            m_op = r[m_owner].op; m_s1 = r[m_owner].s1; m_s2 = r[m_owner].s2; m_d = r[m_owner].d;
        end else begin
            m_op = 3'b000;
        end
        if (m_owner >= 0) begin
            o = m_owner;
            if (!r[o].req) begin
                m_owner = -1;
            end else if (m_held == MAX_BURST - 1) begin
                m_owner = -1;
                m_err   = 1;
                nm[o]   = 1;
            end else begin
                m_held++;
            end
        end else begin
            e0 = r[0].req && !m_mask[0];
            e1 = r[1].req && !m_mask[1];
            if (e0 && !(e1 && m_starve == STARVE_LIMIT)) begin
                m_owner = 0;
                m_held  = 0;
                if (m_cnt[0] < 65535) m_cnt[0]++;
                m_starve = r[1].req ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
            end else if (e1) begin
                m_owner  = 1;
                m_held   = 0;
                m_starve = 0;
                if (m_cnt[1] < 65535) m_cnt[1]++;
            end else if (!r[1].req) begin
                m_starve = 0;
            end
        end
        m_mask = nm;
        e.gnt0 = (m_owner == 0);
        e.gnt1 = (m_owner == 1);
        e.ovf0 = ovf && (m_owner == 0);
        e.ovf1 = ovf && (m_owner == 1);
        e.err  = m_err;
        e.op   = m_op;
        e.s1   = m_s1;
        e.s2   = m_s2;
        e.d    = m_d;
`ifdef ARB_STATS_EN
        e.c0   = 16'(m_cnt[0]);
        e.c1   = 16'(m_cnt[1]);
`else
        e.c0   = 16'h0;
        e.c1   = 16'h0;
`endif
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_gnt0"}, dp.gnt0, 0);
        check({tag, "_gnt1"}, dp.gnt1, 0);
        check({tag, "_op"},   dp.op, 0);
        check({tag, "_src1"}, dp.src1, 0);
        check({tag, "_err"},  dp.err, 0);
`ifdef ARB_STATS_EN
        check({tag, "_cnt0"}, dp.gnt_cnt0, 0);
        check({tag, "_cnt1"}, dp.gnt_cnt1, 0);
`endif
    endtask

    task automatic do_reset(input bit immediate);
        n_rst = 1'b0;
        q.delete();
        model_reset();
        if (immediate) begin
            #1;
            rst_checks("rst_async");
        end
        @(posedge clk);
        #1;
        rst_checks("rst_held");
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued prediction each cycle.
    initial begin
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (n_rst === 1'b1 && q.size() > 0) begin
                a.gnt0 = dp.gnt0; a.gnt1 = dp.gnt1; a.ovf0 = dp.ovf0; a.ovf1 = dp.ovf1;
                a.err  = dp.err;  a.op   = dp.op;   a.s1   = dp.src1; a.s2   = dp.src2;
                a.d    = dp.dest;
`ifdef ARB_STATS_EN
                a.c0 = dp.gnt_cnt0;
                a.c1 = dp.gnt_cnt1;
`else
                a.c0 = 16'h0;
                a.c1 = 16'h0;
`endif
                check("bus", 64'(a), 64'(q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rq_t a0, idle;
        bit  want[2];
        int  rem[2];

        // reset with requester 0 already asking for op 3'b101
        a0   = mk(1, 3'b101);
        idle = mk(0, 3'b000);
        set_inputs(a0, idle, 0);
        do_reset(0);

        drive(a0, idle, 0);
        check("t1_gnt0", dp.gnt0, 1);
        check("t1_op_nop", dp.op, 0);
        drive(a0, idle, 0);
        check("t1_op", dp.op, 3'b101);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);

        // simultaneous requests: req0 first, one NOP turnaround, then req1
        drive(mk(1, 3'($urandom)), mk(1, 3'($urandom)), 0);
        check("t2_gnt0", dp.gnt0, 1);
        check("t2_gnt1_low", dp.gnt1, 0);
        drive(mk(1, 3'($urandom)), mk(1, 3'($urandom)), 0);
        drive(mk(0, 3'($urandom)), mk(1, 3'($urandom)), 0);
        check("t2_turn_gnt0", dp.gnt0, 0);
        check("t2_turn_gnt1", dp.gnt1, 0);
        drive(mk(0, 0), mk(1, 3'b111), 0);
        check("t2_gnt1", dp.gnt1, 1);
        check("t2_nop", dp.op, 0);
        drive(mk(0, 0), mk(1, 3'b110), 0);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);

        // starvation: four req0 grants with req1 pending, fifth goes to req1
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) begin
                drive(mk(1, 3'($urandom)), mk(1, 3'($urandom)), 0);
                check("t3_gnt0", dp.gnt0, 1);
                drive(mk(0, 3'($urandom)), mk(1, 3'($urandom)), 0);
            end
            drive(mk(1, 3'($urandom)), mk(1, 3'($urandom)), 0);
            check("t3_forced_gnt1", dp.gnt1, 1);
            check("t3_forced_gnt0", dp.gnt0, 0);
            drive(mk(1, 3'($urandom)), mk(0, 3'($urandom)), 0);
        end
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);

        // hung burst on requester 1
        for (int k = 1; k <= 70; k++) begin
            drive(mk(0, 0), mk(1, 3'($urandom_range(1, 7))), 0);
            if (k == 64) begin
                check("t4_gnt1_held", dp.gnt1, 1);
                check("t4_err_before", dp.err, 0);
            end
            if (k == 65) begin
                check("t4_released", dp.gnt1, 0);
                check("t4_err", dp.err, 1);
            end
            if (k == 66) check("t4_turn_nop", dp.op, 0);
            if (k == 70) check("t4_masked", dp.gnt1, 0);
        end
        drive(mk(0, 0), mk(0, 0), 0);

        // overflow routing and non-owner op isolation
        drive(mk(0, 3'b011), mk(1, 3'b010), 1);
        check("t5_regrant", dp.gnt1, 1);
        drive(mk(1, 3'b011), mk(1, 3'b010), 1);
        check("t5_ovf1", dp.ovf1, 1);
        check("t5_ovf0", dp.ovf0, 0);
        check("t5_op_owner", dp.op, 3'b010);
        check("t5_err_sticky", dp.err, 1);
        drive(mk(1, 3'b011), mk(1, 3'b010), 0);
        check("t5_op_isolated", dp.op, 3'b010);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);

        // grant counting and reset mid-burst
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 3'($urandom)), mk(0, 0), 0);
            drive(mk(0, 0), mk(0, 0), 0);
        end
        drive(mk(0, 0), mk(1, 3'($urandom)), 0);
        drive(mk(0, 0), mk(1, 3'($urandom)), 0);
`ifdef ARB_STATS_EN
        check("t6_cnt0", dp.gnt_cnt0, 3);
        check("t6_cnt1", dp.gnt_cnt1, 1);
`endif
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(1, 3'b110), mk(0, 0), 0);
        drive(mk(1, 3'b110), mk(0, 0), 0);
        check("t6_burst_gnt0", dp.gnt0, 1);
        check("t6_burst_op", dp.op, 3'b110);
        do_reset(1);

        // randomized bursts from both requesters
        want = '{0, 0};
        rem  = '{0, 0};
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!want[r] && $urandom_range(0, 3) == 0) begin
                    want[r] = 1;
                    rem[r]  = $urandom_range(1, 6);
                end
            end
            drive(mk(want[0], 3'($urandom)), mk(want[1], 3'($urandom)), 1'($urandom));
            for (int r = 0; r < 2; r++) begin
                if (want[r] && m_owner == r) begin
                    rem[r]--;
                    if (rem[r] == 0) want[r] = 0;
                end
            end
        end
        drive(mk(0, 0), mk(0, 0), 0);
        drive(mk(0, 0), mk(0, 0), 0);

        @(posedge clk);
        #2;
        check("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
